wall_map_engine: RTL

// - Parametrised, pipelined wall map. Holds N_RECT programmable wall rectangles and classifies each pixel.
// - For every (DrawX, DrawY) it returns is_Wall and a tiled texture address for the wall sprite ROM.
// - Sits between the VGA controller and the colour mapper.
// - Levels are reprogrammed at run time through a shadow register bank. The shadow bank commits at frame start, so tearing is impossible.

---
 rtl/wall_map_engine.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/wall_map_engine.sv
// Pipelined wall map: N_RECT programmable rectangles, double-buffered config, 2-cycle pixel latency.
// Optional WALL_MAP_HIT_ID_EN adds a hit_id output carrying the winning rectangle index.
module wall_map_engine #(
    parameter int unsigned N_RECT = 8,
    parameter int unsigned TILE_W = 176,
    parameter int unsigned TILE_H = 71,
    parameter int unsigned ADDR_W = 14
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              frame_start,
    input  logic              pix_valid,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              cfg_we,
    input  logic [3:0]        cfg_idx,
    input  logic [2:0]        cfg_field,
    input  logic [9:0]        cfg_data,
    output logic              commit_pending,
    output logic              out_valid,
    output logic              is_Wall,
    output logic [ADDR_W-1:0] Wall_address
`ifdef WALL_MAP_HIT_ID_EN
    ,
    output logic [3:0]        hit_id
`endif
);

    logic [N_RECT-1:0][9:0] sh_x0_q, sh_x1_q, sh_y0_q, sh_y1_q;
    logic [N_RECT-1:0][9:0] act_x0_q, act_x1_q, act_y0_q, act_y1_q;
    logic [N_RECT-1:0]      sh_en_q, act_en_q;
    logic                   pending_q;
    logic                   cfg_ok;

    logic                   s1_valid_q;
    logic [9:0]             s1_x_q, s1_y_q;
    logic [N_RECT-1:0]      s1_hit_q, hit_d;

    logic                   out_valid_q, is_wall_q;
    logic [ADDR_W-1:0]      addr_q, addr_d;

    // Writes to nonexistent rectangles or reserved fields are dropped entirely.
    assign cfg_ok = cfg_we && (32'(cfg_idx) < N_RECT) && (cfg_field <= 3'd4);

    always_comb begin
        hit_d = '0;
        for (int i = 0; i < int'(N_RECT); i++) begin
            hit_d[i] = act_en_q[i]
                    && (DrawX >= act_x0_q[i]) && (DrawX < act_x1_q[i])
                    && (DrawY >= act_y0_q[i]) && (DrawY < act_y1_q[i]);
        end
    end

    assign addr_d = ADDR_W'((32'(s1_x_q) % TILE_W) + (32'(s1_y_q) % TILE_H) * TILE_W);

`ifdef WALL_MAP_HIT_ID_EN
    logic [3:0] id_d, id_q;

    always_comb begin
        id_d = '0;
        for (int i = int'(N_RECT) - 1; i >= 0; i--) begin
            if (s1_hit_q[i]) id_d = 4'(i);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            id_q <= '0;
        end else if (s1_valid_q) begin
            id_q <= id_d;
        end
    end

    assign hit_id = id_q;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            sh_x0_q     <= '0;
            sh_x1_q     <= '0;
            sh_y0_q     <= '0;
            sh_y1_q     <= '0;
            sh_en_q     <= '0;
            act_x0_q    <= '0;
            act_x1_q    <= '0;
            act_y0_q    <= '0;
            act_y1_q    <= '0;
            act_en_q    <= '0;
            pending_q   <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_x_q      <= '0;
            s1_y_q      <= '0;
            s1_hit_q    <= '0;
            out_valid_q <= 1'b0;
            is_wall_q   <= 1'b0;
            addr_q      <= '0;
        end else begin
            // Commit reads the pre-write shadow, so a same-edge write stays pending.
            if (frame_start && pending_q) begin
                act_x0_q <= sh_x0_q;
                act_x1_q <= sh_x1_q;
                act_y0_q <= sh_y0_q;
                act_y1_q <= sh_y1_q;
                act_en_q <= sh_en_q;
            end
            if (cfg_ok) begin
                pending_q <= 1'b1;
                for (int i = 0; i < int'(N_RECT); i++) begin
                    if (cfg_idx == 4'(i)) begin
                        case (cfg_field)
                            3'd0:    sh_x0_q[i] <= cfg_data;
                            3'd1:    sh_x1_q[i] <= cfg_data;
                            3'd2:    sh_y0_q[i] <= cfg_data;
                            3'd3:    sh_y1_q[i] <= cfg_data;
                            default: sh_en_q[i] <= cfg_data[0];
                        endcase
                    end
                end
            end else if (frame_start) begin
                pending_q <= 1'b0;
            end

            s1_valid_q <= pix_valid;
            if (pix_valid) begin
                s1_x_q   <= DrawX;
                s1_y_q   <= DrawY;
                s1_hit_q <= hit_d;
            end

            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                is_wall_q <= |s1_hit_q;
                addr_q    <= (|s1_hit_q) ? addr_d : '0;
            end
        end
    end

    assign commit_pending = pending_q;
    assign out_valid      = out_valid_q;
    assign is_Wall        = is_wall_q;
    assign Wall_address   = addr_q;

endmodule
